// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with an optional one-entry skid buffer, flush/stall
// control from fc, and a saturating count of payloads killed by flush.
module if_id_skid_reg #(
  parameter int unsigned       DATA_W  = 64,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter bit                SKID_EN = 1'b1,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              fc_flush_btype_flag_i,
  input  logic              fc_flush_jtype_flag_i,
  input  logic              fc_stall_flag_i,
  output logic [CNT_W-1:0]  discard_cnt_o
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_HALF  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]        state, state_nx;
  logic [DATA_W-1:0] main_q, main_nx;
  logic [DATA_W-1:0] skid_q, skid_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic              flush, stall, push, pop;
  logic [1:0]        held;
  logic [CNT_W+1:0]  cnt_sum;

  assign flush = fc_flush_btype_flag_i | fc_flush_jtype_flag_i;
  assign stall = fc_stall_flag_i;

  assign out_valid_o = (state != S_EMPTY) & ~flush & ~stall;
  assign out_data_o  = (state != S_EMPTY) ? main_q : RST_VAL;

  // Without the skid entry, a held payload can only be replaced in the same
  // cycle it is consumed, so readiness depends on out_ready_i.
  assign in_ready_o = (SKID_EN ? (state != S_FULL)
                               : ((state == S_EMPTY) | out_ready_i)) & ~flush & ~stall;

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  assign held    = (state == S_FULL) ? 2'd2 : (state == S_HALF) ? 2'd1 : 2'd0;
  assign cnt_sum = {2'b00, cnt_q} + {{CNT_W{1'b0}}, held};

  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    cnt_nx   = cnt_q;
    if (flush) begin
      state_nx = S_EMPTY;
      main_nx  = RST_VAL;
      skid_nx  = RST_VAL;
      cnt_nx   = (cnt_sum[CNT_W+1:CNT_W] != 2'b00) ? '1 : cnt_sum[CNT_W-1:0];
    end else if (!stall) begin
      case (state)
        S_EMPTY: begin
          if (push) begin
            main_nx  = in_data_i;
            state_nx = S_HALF;
          end
        end
        S_HALF: begin
          if (push && pop) begin
            main_nx = in_data_i;
          end else if (push && SKID_EN) begin
            skid_nx  = in_data_i;
            state_nx = S_FULL;
          end else if (pop) begin
            main_nx  = RST_VAL;
            state_nx = S_EMPTY;
          end
        end
        S_FULL: begin
          if (pop) begin
            main_nx  = skid_q;
            skid_nx  = RST_VAL;
            state_nx = S_HALF;
          end
        end
        default: begin
          state_nx = S_EMPTY;
          main_nx  = RST_VAL;
          skid_nx  = RST_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_EMPTY;
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
      cnt_q  <= '0;
    end else begin
      state  <= state_nx;
      main_q <= main_nx;
      skid_q <= skid_nx;
      cnt_q  <= cnt_nx;
    end
  end

  assign discard_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: three configurations driven in lockstep and checked
// against an array-based FIFO model with a saturating discard counter.
module tb_if_id_skid_reg;

  localparam logic [63:0] ONE_RST = 64'hDEAD_BEEF_CAFE_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, fb = 1'b0, fj = 1'b0, stall = 1'b0;
  logic [63:0] in_data = '0;

  logic [2:0]  ov, ir;
  logic [63:0] od [3];
  logic [15:0] cnt0, cnt2;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  if_id_skid_reg u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[0]),
    .in_data_i(in_data), .out_valid_o(ov[0]), .out_ready_i(out_ready),
    .out_data_o(od[0]), .fc_flush_btype_flag_i(fb), .fc_flush_jtype_flag_i(fj),
    .fc_stall_flag_i(stall), .discard_cnt_o(cnt0)
  );

  if_id_skid_reg #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[1]),
    .in_data_i(in_data), .out_valid_o(ov[1]), .out_ready_i(out_ready),
    .out_data_o(od[1]), .fc_flush_btype_flag_i(fb), .fc_flush_jtype_flag_i(fj),
    .fc_stall_flag_i(stall), .discard_cnt_o(cnt1)
  );

  if_id_skid_reg #(.SKID_EN(1'b0), .RST_VAL(ONE_RST)) u_one (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[2]),
    .in_data_i(in_data), .out_valid_o(ov[2]), .out_ready_i(out_ready),
    .out_data_o(od[2]), .fc_flush_btype_flag_i(fb), .fc_flush_jtype_flag_i(fj),
    .fc_stall_flag_i(stall), .discard_cnt_o(cnt2)
  );

  // Reference model: per instance a bounded FIFO (capacity 2 or 1) plus counter.
  int unsigned cap  [3] = '{2, 2, 1};
  int unsigned cmax [3] = '{65535, 3, 65535};
  logic [63:0] rstv [3] = '{64'h0, 64'h0, ONE_RST};
  logic [63:0] mq   [3][2];
  int unsigned msz  [3];
  int unsigned mcnt [3];

  int tests = 0;
  int fails = 0;

  function automatic logic [15:0] cnt_of(input int i);
    if (i == 0) return cnt0;
    if (i == 1) return {14'b0, cnt1};
    return cnt2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic mdl_valid(input int i);
    return (msz[i] > 0) && !(fb | fj) && !stall;
  endfunction

  function automatic logic mdl_ready(input int i);
    return !(fb | fj) && !stall && ((msz[i] < cap[i]) || (cap[i] == 1 && out_ready));
  endfunction

  task automatic check_all(input string ph);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.valid[%0d]", ph, i), 64'(ov[i]), 64'(mdl_valid(i)));
      chk($sformatf("%s.ready[%0d]", ph, i), 64'(ir[i]), 64'(mdl_ready(i)));
      chk($sformatf("%s.data[%0d]", ph, i), od[i], (msz[i] > 0) ? mq[i][0] : rstv[i]);
      chk($sformatf("%s.cnt[%0d]", ph, i), 64'(cnt_of(i)), 64'(mcnt[i]));
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      logic do_pop, do_push;
      do_pop  = mdl_valid(i) && out_ready;
      do_push = in_valid && mdl_ready(i);
      if (fb | fj) begin
        mcnt[i] = (mcnt[i] + msz[i] > cmax[i]) ? cmax[i] : mcnt[i] + msz[i];
        msz[i]  = 0;
      end else if (!stall) begin
        if (do_pop) begin
          mq[i][0] = mq[i][1];
          msz[i]--;
        end
        if (do_push) begin
          mq[i][msz[i]] = in_data;
          msz[i]++;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      msz[i]  = 0;
      mcnt[i] = 0;
    end
  endtask

  // One cycle: drive, check pre-edge outputs, advance model at the edge.
  task automatic step(input string ph, input logic v, input logic [63:0] d,
                      input logic r, input logic b, input logic j, input logic s);
    in_valid = v; in_data = d; out_ready = r; fb = b; fj = j; stall = s;
    #1;
    check_all(ph);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  localparam logic [63:0] A = 64'hAAAA_0000_0000_000A;
  localparam logic [63:0] B = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] C = 64'hCCCC_0000_0000_000C;
  localparam logic [63:0] D = 64'hDDDD_0000_0000_000D;

  initial begin
    int unsigned sat_exp [4] = '{2, 3, 3, 3};
    model_reset();

    // Reset state, with in_ready following stall while in reset
    #2;
    check_all("rst");
    stall = 1'b1;
    #1;
    check_all("rst_stall");
    stall = 1'b0;
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming at full rate
    step("stream1", 1, 64'h1000_0000_0000_0001, 1, 0, 0, 0);
    step("stream2", 1, 64'h1000_0000_0000_0002, 1, 0, 0, 0);
    step("stream3", 1, 64'h1000_0000_0000_0003, 1, 0, 0, 0);
    step("stream4", 0, '0, 1, 0, 0, 0);
    step("stream5", 0, '0, 1, 0, 0, 0);

    // Backpressure into FULL, then drain in order
    step("bp_a", 1, A, 0, 0, 0, 0);
    step("bp_b", 1, B, 0, 0, 0, 0);
    step("bp_full", 1, C, 0, 0, 0, 0);
    step("bp_pop1", 0, '0, 1, 0, 0, 0);
    step("bp_pop2", 0, '0, 1, 0, 0, 0);
    step("bp_empty", 0, '0, 1, 0, 0, 0);

    // Stall while HALF holds the payload, release pops it
    step("st_push", 1, D, 1, 0, 0, 0);
    step("st_hold1", 1, A, 1, 0, 0, 1);
    step("st_hold2", 0, '0, 1, 0, 0, 1);
    step("st_rel", 0, '0, 1, 0, 0, 0);
    step("st_empty", 0, '0, 1, 0, 0, 0);

    // Flush of an empty buffer is not counted
    step("fl_empty", 1, A, 1, 1, 0, 0);

    // Saturation of the 2-bit counter over four FULL flushes
    for (int k = 0; k < 4; k++) begin
      step("sat_a", 1, A + 64'(k), 0, 0, 0, 0);
      step("sat_b", 1, B + 64'(k), 0, 0, 0, 0);
      step("sat_fl", 1, C, 0, k[0], ~k[0], 0);
      step("sat_chk", 0, '0, 0, 0, 0, 0);
      chk($sformatf("sat_cnt%0d", k), 64'(cnt1), 64'(sat_exp[k]));
    end

    // Jump flush of FULL with a concurrent upstream payload
    step("jf_a", 1, A, 0, 0, 0, 0);
    step("jf_b", 1, B, 0, 0, 0, 0);
    step("jf_flush", 1, C, 1, 0, 1, 0);
    step("jf_after", 0, '0, 0, 0, 0, 0);
    chk("jf_cnt", 64'(cnt0), 64'd10);

    // Asynchronous reset mid-cycle while FULL
    step("ar_a", 1, A, 0, 0, 0, 0);
    step("ar_b", 1, B, 0, 0, 0, 0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("ar_rst");
    chk("ar_cnt0", 64'(cnt0), 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("ar_idle", 0, '0, 1, 0, 0, 0);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      step("rnd", ($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 3) != 0,
           ($urandom % 16) == 0, ($urandom % 20) == 0, ($urandom % 8) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
